// File: rtl/shift_add_multiplier_if.sv
// Request/result bundle for the 8x8 shift-and-add multiplier.
// start/a/b go caller->multiplier; p/busy/done come back.
interface shift_add_multiplier_if;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] p;
  logic        busy;
  logic        done;

  modport master (
    output start, a, b,
    input  p, busy, done
  );

  modport slave (
    input  start, a, b,
    output p, busy, done
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential 8x8 unsigned shift-and-add multiplier, 16-bit product.
// Ports: clk, rst_n (async low), bus (slave: start,a,b -> p,busy,done).
module shift_add_multiplier (
  input  logic                   clk,
  input  logic                   rst_n,
  shift_add_multiplier_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] mcand_q, mcand_d;
  logic [7:0]  mplr_q, mplr_d;
  logic [15:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] p_q, p_d;

  logic [15:0] sum;
  logic        add_co_unused;

  // Subtract select and carry-in tied low: pure acc + mcand.
  // Carry-out cannot be set for 8x8 operands.
  Sixteen_b_full_adder u_add (
    .a_i (acc_q),
    .b_i (mcand_q),
    .x_i (1'b0),
    .c_i (1'b0),
    .s_o (sum),
    .c_o (add_co_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d = {8'h00, bus.a};
          mplr_d  = bus.b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = mplr_q[0] ? sum : acc_q;
        mcand_d = {mcand_q[14:0], 1'b0};
        mplr_d  = {1'b0, mplr_q[7:1]};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          p_d     = acc_d;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status is decoded from state only; the 2'b11 encoding reads idle.
  assign bus.busy = (state_q == RUN) || (state_q == DONE);
  assign bus.done = (state_q == DONE);
  assign bus.p    = p_q;

endmodule

// 16-bit ripple adder/subtractor: x_i=1 subtracts (b inverted).
module Sixteen_b_full_adder (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        x_i,
  input  logic        c_i,
  output logic [15:0] s_o,
  output logic        c_o
);

  logic c;
  logic bx;

  always_comb begin
    s_o = '0;
    c   = c_i;
    bx  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bx     = b_i[i] ^ x_i;
      s_o[i] = a_i[i] ^ bx ^ c;
      c      = (a_i[i] & bx) | (c & (a_i[i] ^ bx));
    end
    c_o = c;
  end

endmodule
